audio_slot_sched: RTL and testbench

Weighted round-robin time-slot scheduler for the shared per-channel audio DACs. The speaker, SpecDrum and six PSG channels take turns driving the left/right DAC inputs, and this block decides which source owns the current clock slot. The CPU-side I/O decoder configures it through a small register file: per-source enable and slot weight. Its `source` output drives the mixer's select mux in place of a free-running counter.

---
 rtl/audio_slot_sched_pkg.sv | 23 ++
 rtl/audio_slot_sched_if.sv | 13 +
 rtl/audio_slot_pick.sv | 34 +++
 rtl/audio_slot_sched.sv | 89 ++++++++
 tb/tb_audio_slot_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_slot_sched_pkg.sv
// Shared constants for the audio DAC slot scheduler: sizes, source indices,
// register bit positions, FSM encoding and register reset value.
package audio_pkg;

    localparam int NSRC_DEF  = 6;
    localparam int WBITS_DEF = 3;

    localparam logic [2:0] SRC_SPK    = 3'd0;
    localparam logic [2:0] SRC_DRUM   = 3'd1;
    localparam logic [2:0] SRC_PSG1AC = 3'd2;
    localparam logic [2:0] SRC_PSG1B  = 3'd3;
    localparam logic [2:0] SRC_PSG2AC = 3'd4;
    localparam logic [2:0] SRC_PSG2B  = 3'd5;

    localparam int EN_BIT = 7;
    localparam int W_LSB  = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [7:0] REG_RST = 8'h80;

endpackage

// File: rtl/audio_slot_sched_if.sv
// CPU-side configuration port of the slot scheduler: write strobe, index,
// write data and combinational readback.
interface audio_slot_sched_if;

    logic       cfgWr;
    logic [2:0] cfgAddr;
    logic [7:0] cfgD;
    logic [7:0] cfgQ;

    modport master (output cfgWr, output cfgAddr, output cfgD, input cfgQ);
    modport slave  (input cfgWr, input cfgAddr, input cfgD, output cfgQ);

endinterface

// File: rtl/audio_slot_pick.sv
// Next-enabled-source search: scans upward from cur+1 with wrap at NSRC-1,
// so cur = NSRC-1 yields the lowest-index enabled source.
module audio_slot_pick
    import audio_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic [NSRC-1:0] en,
    input  logic [2:0]      cur,
    output logic [2:0]      nxt,
    output logic            none
);

    int idx;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop leaves it unassigned and infers a latch.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        idx  = 0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = int'(cur) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (none && en[idx]) begin
                nxt  = 3'(idx);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_slot_sched.sv
// Weighted round-robin owner of the shared audio DAC slot; a source with
// weight w holds the slot for w+1 cycles, disabled sources are skipped.
module audio_slot_sched
    import audio_pkg::*;
#(
    parameter int NSRC  = NSRC_DEF,
    parameter int WBITS = WBITS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    audio_slot_sched_if.slave   cfg,
    output logic [2:0]          source,
    output logic                active,
    output logic                slotStart
);

    logic [7:0]       regs [NSRC];
    logic [NSRC-1:0]  en;
    logic [0:0]       state;
    logic [WBITS-1:0] remain;
    logic [2:0]       pick_cur;
    logic [2:0]       pick_nxt;
    logic             pick_none;
    logic             addr_ok;
    logic             owner_off;
    logic             boundary;

    always_comb begin
        addr_ok = int'(cfg.cfgAddr) < NSRC;
        cfg.cfgQ = addr_ok ? regs[cfg.cfgAddr] : 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            en[i] = regs[i][EN_BIT];
        end
        // A write clearing the owner's enable ends its slot at that same edge;
        // the search itself still sees the pre-write enables.
        owner_off = !en[source] ||
                    (cfg.cfgWr && (cfg.cfgAddr == source) && !cfg.cfgD[EN_BIT]);
        boundary  = (remain == '0) || owner_off;
        pick_cur  = (state == ST_IDLE) ? 3'(NSRC - 1) : source;
    end

    audio_slot_pick #(.NSRC(NSRC)) u_pick (
        .en   (en),
        .cur  (pick_cur),
        .nxt  (pick_nxt),
        .none (pick_none)
    );

    // NOTE: the register file is a handful of flops, not a RAM, and its
    // contents are architecturally defined after reset, so it is reset too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSRC; i++) begin
                regs[i] <= REG_RST;
            end
        end else if (cfg.cfgWr && addr_ok) begin
            regs[cfg.cfgAddr] <= cfg.cfgD;
        end
    end

    // NOTE: non-blocking assignments throughout; the slotStart default below
    // is overridden by the later assignment in the same edge when a slot loads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            source    <= '0;
            active    <= 1'b0;
            slotStart <= 1'b0;
            remain    <= '0;
        end else begin
            slotStart <= 1'b0;
            if ((state == ST_IDLE) || boundary) begin
                if (pick_none) begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end else begin
                    state     <= ST_RUN;
                    source    <= pick_nxt;
                    active    <= 1'b1;
                    slotStart <= 1'b1;
                    remain    <= regs[pick_nxt][W_LSB +: WBITS];
                end
            end else begin
                remain <= remain - WBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_slot_sched.sv
// Directed bench for audio_slot_sched: table-driven slot sequences plus
// hand-written sequences for disable, idle re-entry and async reset.
module tb_audio_slot_sched;
    import audio_pkg::*;

    typedef struct {
        logic [2:0] src;
        logic       act;
        logic       ss;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] source;
    logic       active;
    logic       slotStart;

    int n_checks = 0;
    int n_errors = 0;

    audio_slot_sched_if cfg();

    audio_slot_sched #(.NSRC(NSRC_DEF), .WBITS(WBITS_DEF)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg       (cfg),
        .source    (source),
        .active    (active),
        .slotStart (slotStart)
    );

    always #5 clock = ~clock;

    vec_t t2 [9] = '{
        '{SRC_SPK,    1'b1, 1'b1}, '{SRC_DRUM,   1'b1, 1'b1},
        '{SRC_DRUM,   1'b1, 1'b0}, '{SRC_DRUM,   1'b1, 1'b0},
        '{SRC_DRUM,   1'b1, 1'b0}, '{SRC_PSG1AC, 1'b1, 1'b1},
        '{SRC_PSG1B,  1'b1, 1'b1}, '{SRC_PSG2AC, 1'b1, 1'b1},
        '{SRC_PSG2B,  1'b1, 1'b1}
    };
    vec_t t3 [3] = '{
        '{SRC_PSG2AC, 1'b1, 1'b1}, '{SRC_PSG2AC, 1'b1, 1'b0},
        '{SRC_PSG2AC, 1'b1, 1'b0}
    };
    vec_t t4 [6] = '{
        '{SRC_PSG2AC, 1'b1, 1'b1}, '{SRC_PSG2B,  1'b1, 1'b1},
        '{SRC_SPK,    1'b1, 1'b1}, '{SRC_DRUM,   1'b1, 1'b1},
        '{SRC_PSG1AC, 1'b1, 1'b1}, '{SRC_PSG2AC, 1'b1, 1'b1}
    };

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input vec_t e);
        check({tag, " source"},    {5'b0, source},    {5'b0, e.src});
        check({tag, " active"},    {7'b0, active},    {7'b0, e.act});
        check({tag, " slotStart"}, {7'b0, slotStart}, {7'b0, e.ss});
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // Leaves the bench at the negedge of cycle 0 after release, reset state checked.
    task automatic do_reset;
        reset       = 1'b0;
        cfg.cfgWr   = 1'b0;
        cfg.cfgAddr = 3'd0;
        cfg.cfgD    = 8'h00;
        tick;
        tick;
        check_out("in reset", '{3'd0, 1'b0, 1'b0});
        reset = 1'b1;
        check_out("cycle0", '{3'd0, 1'b0, 1'b0});
    endtask

    task automatic write_set(input logic [2:0] addr, input logic [7:0] d);
        cfg.cfgWr   = 1'b1;
        cfg.cfgAddr = addr;
        cfg.cfgD    = d;
    endtask

    initial begin
        // Default rotation 0..5, one cycle each.
        do_reset;
        for (int k = 0; k < 12; k++) begin
            tick;
            check_out($sformatf("default c%0d", k + 1), '{3'(k % 6), 1'b1, 1'b1});
        end

        // Source 1 weight 3: period 9.
        do_reset;
        write_set(3'd1, 8'h83);
        tick;
        cfg.cfgWr = 1'b0;
        check("w3 readback reg1", cfg.cfgQ, 8'h83);
        for (int i = 0; i < 18; i++) begin
            check_out($sformatf("w3 c%0d", i + 1), t2[i % 9]);
            tick;
        end

        // Only source 4 enabled, weight 2.
        do_reset;
        for (int i = 0; i < 6; i++) begin
            write_set(3'(i), (i == 4) ? 8'h82 : 8'h00);
            tick;
        end
        cfg.cfgWr = 1'b0;
        tick;
        for (int i = 0; i < 9; i++) begin
            check_out($sformatf("solo4 c%0d", i + 7), t3[i % 3]);
            tick;
        end

        // Disable source 3 mid-slot (weight 5, remain 3).
        do_reset;
        write_set(3'd3, 8'h85);
        tick;
        cfg.cfgWr = 1'b0;
        tick; tick; tick;
        check_out("kill c4", '{3'd3, 1'b1, 1'b1});
        tick;
        check_out("kill c5", '{3'd3, 1'b1, 1'b0});
        tick;
        check_out("kill c6", '{3'd3, 1'b1, 1'b0});
        write_set(3'd3, 8'h00);
        tick;
        cfg.cfgWr = 1'b0;
        check("kill readback reg3", cfg.cfgQ, 8'h00);
        for (int i = 0; i < 6; i++) begin
            check_out($sformatf("kill c%0d", i + 7), t4[i]);
            tick;
        end

        // All disabled -> IDLE, then re-enable source 2.
        do_reset;
        for (int i = 0; i < 6; i++) begin
            write_set(3'(i), 8'h00);
            tick;
        end
        cfg.cfgWr = 1'b0;
        check_out("idle c6", '{3'd5, 1'b1, 1'b1});
        tick;
        check("idle c7 active", {7'b0, active}, 8'h00);
        check("idle c7 slotStart", {7'b0, slotStart}, 8'h00);
        tick;
        check("idle c8 active", {7'b0, active}, 8'h00);
        write_set(3'd2, 8'h80);
        tick;
        cfg.cfgWr = 1'b0;
        check("idle c9 active", {7'b0, active}, 8'h00);
        tick;
        check_out("wake c10", '{3'd2, 1'b1, 1'b1});
        tick;
        check_out("wake c11", '{3'd2, 1'b1, 1'b1});

        // Async reset mid-slot, then out-of-range address.
        do_reset;
        write_set(3'd1, 8'h87);
        tick;
        cfg.cfgWr = 1'b0;
        check_out("rst c1", '{3'd0, 1'b1, 1'b1});
        tick;
        check_out("rst c2", '{3'd1, 1'b1, 1'b1});
        check("rst readback reg1", cfg.cfgQ, 8'h87);
        tick;
        check_out("rst c3", '{3'd1, 1'b1, 1'b0});
        #2;
        reset = 1'b0;
        #1;
        check_out("async reset", '{3'd0, 1'b0, 1'b0});
        check("async reset reg1", cfg.cfgQ, 8'h80);
        cfg.cfgAddr = 3'd7;
        #1;
        check("addr7 read", cfg.cfgQ, 8'h00);
        tick;
        reset = 1'b1;
        write_set(3'd7, 8'hFF);
        tick;
        cfg.cfgWr = 1'b0;
        check_out("after rst c1", '{3'd0, 1'b1, 1'b1});
        #1;
        check("addr7 after write", cfg.cfgQ, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cfg.cfgAddr = 3'(i);
            #1;
            check($sformatf("reg%0d after addr7 write", i), cfg.cfgQ, REG_RST);
        end
        tick;
        check_out("after rst c2", '{3'd1, 1'b1, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
